// File: rtl/soc_bus_arbiter_if.sv
// Requester and bus-master signal bundle for soc_bus_arbiter.
// The master modport is the arbiter's view; slave is the requesters plus the bus.
interface soc_bus_arbiter_if;
    logic       r0_valid, r1_valid;
    logic [7:0] r0_addr,  r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_we,    r1_we;
    logic       r0_lock,  r1_lock;
    logic       r0_ready, r1_ready;
    logic [7:0] r0_rdata, r1_rdata;
    logic       r0_err,   r1_err;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_valid;
    logic [7:0] bus_rdata;
    logic       bus_ready;

    modport master (
        input  r0_valid, r0_addr, r0_wdata, r0_we, r0_lock,
        input  r1_valid, r1_addr, r1_wdata, r1_we, r1_lock,
        output r0_ready, r0_rdata, r0_err,
        output r1_ready, r1_rdata, r1_err,
        output bus_addr, bus_wdata, bus_we, bus_valid,
        input  bus_rdata, bus_ready
    );

    modport slave (
        output r0_valid, r0_addr, r0_wdata, r0_we, r0_lock,
        output r1_valid, r1_addr, r1_wdata, r1_we, r1_lock,
        input  r0_ready, r0_rdata, r0_err,
        input  r1_ready, r1_rdata, r1_err,
        input  bus_addr, bus_wdata, bus_we, bus_valid,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/soc_bus_arbiter.sv
// Two-requester round-robin arbiter with short-burst lock, bus-timeout watchdog
// and registered bus/response outputs. One transaction in flight at a time.
module soc_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    soc_bus_arbiter_if.master   arb
);
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned TW = 8;
    localparam int unsigned HW = 4;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e        state_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;
    logic          bus_we_q;
    logic          bus_valid_q;
    logic          r0_ready_q, r1_ready_q;
    logic [DW-1:0] r0_rdata_q, r1_rdata_q;
    logic          r0_err_q,   r1_err_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          grant_q;
    logic          last_grant_q;
    logic          lock_vld_q;
    logic          lock_owner_q;
    logic [HW-1:0] hold_cnt_q;
    logic [TW-1:0] tmo_cnt_q;

    logic          any_req;
    logic          owner_req;
    logic          lock_win;
    logic          winner;
    logic          win_lock;
    logic          other_req;

    // Winner selection for IDLE and lock bookkeeping inputs for RESP
    always_comb begin
        any_req   = arb.r0_valid | arb.r1_valid;
        owner_req = lock_owner_q ? arb.r1_valid : arb.r0_valid;
        lock_win  = lock_vld_q && owner_req && (hold_cnt_q < HOLD_MAX);
        winner    = arb.r1_valid;
        if (lock_win) begin
            winner = lock_owner_q;
        end else if (arb.r0_valid && arb.r1_valid) begin
            winner = ~last_grant_q;
        end
        win_lock  = grant_q ? arb.r1_lock  : arb.r0_lock;
        other_req = grant_q ? arb.r0_valid : arb.r1_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_we_q     <= 1'b0;
            bus_valid_q  <= 1'b0;
            r0_ready_q   <= 1'b0;
            r1_ready_q   <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_vld_q   <= 1'b0;
            lock_owner_q <= 1'b0;
            hold_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            r0_ready_q <= 1'b0;
            r1_ready_q <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q     <= winner;
                        bus_addr_q  <= winner ? arb.r1_addr  : arb.r0_addr;
                        bus_wdata_q <= winner ? arb.r1_wdata : arb.r0_wdata;
                        bus_we_q    <= winner ? arb.r1_we    : arb.r0_we;
                        bus_valid_q <= 1'b1;
                        tmo_cnt_q   <= '0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A ready on the final watchdog cycle still counts as success
                    if (arb.bus_ready) begin
                        rdata_q     <= arb.bus_rdata;
                        err_q       <= 1'b0;
                        bus_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rdata_q     <= 8'hFF;
                        err_q       <= 1'b1;
                        bus_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + TW'(1);
                    end
                end
                RESP: begin
                    if (grant_q) begin
                        r1_ready_q <= 1'b1;
                        r1_rdata_q <= rdata_q;
                        r1_err_q   <= err_q;
                    end else begin
                        r0_ready_q <= 1'b1;
                        r0_rdata_q <= rdata_q;
                        r0_err_q   <= err_q;
                    end
                    last_grant_q <= grant_q;
                    // hold_cnt counts re-grants won through the lock by its current owner
                    if (!win_lock) begin
                        lock_vld_q <= 1'b0;
                        hold_cnt_q <= '0;
                    end else if (lock_vld_q && (lock_owner_q == grant_q)) begin
                        if (!other_req) begin
                            hold_cnt_q <= '0;
                        end else if (hold_cnt_q != HOLD_MAX) begin
                            hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                    end else begin
                        lock_vld_q   <= 1'b1;
                        lock_owner_q <= grant_q;
                        hold_cnt_q   <= '0;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.bus_addr  = bus_addr_q;
    assign arb.bus_wdata = bus_wdata_q;
    assign arb.bus_we    = bus_we_q;
    assign arb.bus_valid = bus_valid_q;
    assign arb.r0_ready  = r0_ready_q;
    assign arb.r1_ready  = r1_ready_q;
    assign arb.r0_rdata  = r0_rdata_q;
    assign arb.r1_rdata  = r1_rdata_q;
    assign arb.r0_err    = r0_err_q;
    assign arb.r1_err    = r1_err_q;
endmodule

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Two-requester arbiter in front of the SoC bus master port, which has a single valid/ready/addr/wdata/we/rdata interface.
- Requester 0 is the CPU; requester 1 is the DMA/debug engine.
- Sequences one bus transaction at a time and registers all bus-side outputs.
- Round-robin fairness, an optional per-requester lock for short bursts, a bus-timeout watchdog and an error response.

Parameters:
- TIMEOUT, 16: cycles in ACCESS without bus_ready before aborting with error (range 2..255).
- MAX_HOLD, 4: maximum consecutive locked grants to one requester while the other is waiting (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- r0_valid, r1_valid  input  1  request pending; held stable with its fields until the matching ready.
- r0_addr, r1_addr  input  8  byte address.
- r0_wdata, r1_wdata  input  8  write data.
- r0_we, r1_we  input  1  1 = write, 0 = read.
- r0_lock, r1_lock  input  1  request to keep the grant for the next transaction.
- r0_ready, r1_ready  output  1  one-cycle completion pulse.
- r0_rdata, r1_rdata  output  8  read data, valid while the matching ready is high.
- r0_err, r1_err  output  1  timeout error, valid while the matching ready is high.
- bus_addr  output  8  registered to the bus master port.
- bus_wdata  output  8  registered to the bus master port.
- bus_we  output  1  registered to the bus master port.
- bus_valid  output  1  registered to the bus master port.
- bus_rdata  input  8  from the bus.
- bus_ready  input  1  from the bus.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, bus_valid=0, bus_addr/wdata=0, bus_we=0, all rN_ready/rN_rdata/rN_err=0, last_grant=1 (r0 wins the first tie), lock_owner cleared, hold_cnt=0, tmo_cnt=0. Reset mid-transaction drops it with no ready pulse.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, winner selection when any rN_valid=1:
  - Lock override: if lock_owner is set, that requester is valid, and hold_cnt<MAX_HOLD, the lock owner wins.
  - Otherwise, if both are valid, the winner is the requester != last_grant.
  - Otherwise, the single valid requester wins.
- IDLE, on a win: latch the winner's addr/wdata/we into bus_*; set bus_valid=1; tmo_cnt=0; go to ACCESS.
- IDLE with no request: stay in IDLE.
- Request fields are sampled only at this IDLE->ACCESS edge; later changes are ignored.
- ACCESS, bus_ready=1: capture bus_rdata; err=0; bus_valid=0; go to RESP.
- ACCESS, bus_ready=0: tmo_cnt++. When tmo_cnt reaches TIMEOUT-1 with bus_ready still 0 (TIMEOUT ACCESS cycles total): rdata=8'hFF, err=1, bus_valid=0, go to RESP.
- ACCESS, simultaneous: bus_ready=1 on the timeout cycle counts as success, not error.
- RESP: winner's rN_ready=1 for exactly one cycle with its rN_rdata/rN_err. The loser's ready, rdata and err stay 0. last_grant=winner. Go to IDLE.
- Lock update in RESP, winner's lock=1:
  - lock_owner=winner.
  - hold_cnt++ if the other requester's valid=1, else hold_cnt=0.
- Lock update in RESP, winner's lock=0: clear lock_owner and hold_cnt.
- hold_cnt saturates at MAX_HOLD. Once at MAX_HOLD, round-robin applies, and the lock and hold_cnt clear when the other requester is granted.
- Timing:
  - Minimum 3 cycles per transaction: request seen in IDLE, ACCESS, RESP.
  - With an always-ready bus, rN_ready rises 2 cycles after the rising edge at which valid is first sampled.
  - Back-to-back throughput is one transaction per 3 cycles.
- Protocol violation: if a requester deasserts valid before its ready, the latched transaction still completes and the ready pulse is still issued. The requester must ignore it.
- Writes: rN_rdata is don't-care. The bench checks only rN_ready and rN_err.
- Outputs are registered. There is no combinational path from any rN_* or bus_* input to any output.

Test Plan:
- r0 alone reads addr 8'h10 with the bus returning 8'h5A at once -> bus_valid high exactly 1 cycle with bus_addr=8'h10, bus_we=0; r0_ready pulses 2 cycles later with r0_rdata=8'h5A, r0_err=0; r1_ready stays 0.
- r0 and r1 request continuously with lock=0 (r0 write 8'h90<-8'h01, r1 read 8'h20) -> grants alternate r0, r1, r0, r1; first grant goes to r0 after reset; one ready pulse every 3 cycles.
- r1 holds lock=1 with 6 back-to-back reads while r0 is valid, MAX_HOLD=4 -> r1 gets its grant plus 4 locked grants, then r0 is granted; no requester waits more than MAX_HOLD+1 transactions.
- bus_ready held 0 for 20 cycles, TIMEOUT=16 -> bus_valid drops after exactly 16 ACCESS cycles; rN_ready pulses with rN_rdata=8'hFF, rN_err=1; the next request proceeds normally.
- bus_ready rises on the 16th ACCESS cycle -> success: err=0 and the captured data is returned.
- rst asserted for 1 cycle while in ACCESS -> next cycle all outputs are at reset values; no ready pulse; a new r1 request completes normally.
